demux1a2_32bit_buf: RTL and testbench

DEMUX1A2_32BIT_BUF -- requirements
Module: demux1a2_32bit_buf

---
 rtl/demux1a2_32bit_buf.sv | 84 ++++++++
 tb/tb_demux1a2_32bit_buf.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux1a2_32bit_buf.sv
// Routes each input word to one of two independent 2-entry FIFOs selected by SEL, and counts the words accepted per path.
// Latency: a word is at the head of an empty path one cycle after it is presented. Backpressure: IN_READY is low while the selected path is full.
module demux1a2_32bit_buf #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic             SEL,
    input  logic [31:0]      IN,
    output logic             OUT0_VALID,
    input  logic             OUT0_READY,
    output logic [31:0]      OUT0,
    output logic             OUT1_VALID,
    input  logic             OUT1_READY,
    output logic [31:0]      OUT1,
    output logic [CNT_W-1:0] CNT0,
    output logic [CNT_W-1:0] CNT1
);

    logic [31:0]      head [2];
    logic [31:0]      tail [2];
    logic [1:0]       occ  [2];
    logic [CNT_W-1:0] cnt  [2];
    logic             full    [2];
    logic             push    [2];
    logic             pop     [2];
    logic             out_rdy [2];

    always_comb begin
        out_rdy[0] = OUT0_READY;
        out_rdy[1] = OUT1_READY;
        for (int i = 0; i < 2; i++) begin
            full[i] = (occ[i] == 2'd2);
        end
        // Ready depends only on the selected path, never on IN_VALID.
        IN_READY = SEL ? !full[1] : !full[0];
        for (int i = 0; i < 2; i++) begin
            push[i] = IN_VALID && IN_READY && (SEL == 1'(i));
            pop[i]  = (occ[i] != 2'd0) && out_rdy[i];
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_path
        always_ff @(posedge CLK) begin
            if (RST) begin
                occ[p]  <= 2'd0;
                head[p] <= '0;
                tail[p] <= '0;
                cnt[p]  <= '0;
            end else begin
                unique case ({push[p], pop[p]})
                    2'b10: begin
                        if (occ[p] == 2'd0) begin
                            head[p] <= IN;
                        end else begin
                            tail[p] <= IN;
                        end
                        occ[p] <= occ[p] + 2'd1;
                    end
                    2'b01: begin
                        head[p] <= tail[p];
                        occ[p]  <= occ[p] - 2'd1;
                    end
                    // Push+pop only happens at occupancy 1: the new word replaces the head.
                    2'b11: head[p] <= IN;
                    default: ;
                endcase
                if (push[p]) begin
                    cnt[p] <= cnt[p] + 1'b1;
                end
            end
        end
    end

    assign OUT0_VALID = (occ[0] != 2'd0);
    assign OUT1_VALID = (occ[1] != 2'd0);
    assign OUT0       = OUT0_VALID ? head[0] : 32'h0;
    assign OUT1       = OUT1_VALID ? head[1] : 32'h0;
    assign CNT0       = cnt[0];
    assign CNT1       = cnt[1];

endmodule

// File: tb/tb_demux1a2_32bit_buf.sv
// Bench for demux1a2_32bit_buf: directed scenarios plus random traffic against a per-path queue model.
module tb_demux1a2_32bit_buf;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          sel = 1'b0;
    logic [31:0]   in_dat = 32'h0;
    logic          out0_valid, out1_valid;
    logic          out0_ready = 1'b0;
    logic          out1_ready = 1'b0;
    logic [31:0]   out0, out1;
    logic [CW-1:0] cnt0, cnt1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    int          m_cnt0 = 0;
    int          m_cnt1 = 0;

    demux1a2_32bit_buf #(.CNT_W(CW)) dut (
        .CLK        (clk),
        .RST        (rst),
        .IN_VALID   (in_valid),
        .IN_READY   (in_ready),
        .SEL        (sel),
        .IN         (in_dat),
        .OUT0_VALID (out0_valid),
        .OUT0_READY (out0_ready),
        .OUT0       (out0),
        .OUT1_VALID (out1_valid),
        .OUT1_READY (out1_ready),
        .OUT1       (out1),
        .CNT0       (cnt0),
        .CNT1       (cnt1)
    );

    always #5 clk = ~clk;

    // Advance one clock and update the model from the inputs held across the edge.
    task automatic tick();
        bit          acc, p0, p1, s;
        logic [31:0] d;
        s   = sel;
        d   = in_dat;
        acc = in_valid && ((s ? q1.size() : q0.size()) < 2);
        p0  = out0_ready && (q0.size() > 0);
        p1  = out1_ready && (q1.size() > 0);
        @(posedge clk);
        if (rst) begin
            q0.delete();
            q1.delete();
            m_cnt0 = 0;
            m_cnt1 = 0;
        end else begin
            if (p0) void'(q0.pop_front());
            if (p1) void'(q1.pop_front());
            if (acc) begin
                if (s) begin
                    q1.push_back(d);
                    m_cnt1++;
                end else begin
                    q0.push_back(d);
                    m_cnt0++;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic idle_inputs();
        in_valid   = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        sel        = 1'b0;
        in_dat     = 32'h0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 20; i++) begin
            in_valid   = 1'($urandom);
            sel        = 1'($urandom);
            in_dat     = $urandom;
            out0_ready = 1'($urandom);
            out1_ready = 1'($urandom);
            tick();
        end
        in_valid   = 1'b1;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        do_reset();
        in_valid = 1'b0;
        sel      = 1'b0;
        #1;
        n_checks++;
        if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b/%b want 0/0", out0_valid, out1_valid);
        end
        n_checks++;
        if (out0 !== 32'h0 || out1 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h/%h want 0/0", out0, out1);
        end
        n_checks++;
        if (cnt0 !== 4'd0 || cnt1 !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %0d/%0d want 0/0", cnt0, cnt1);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_sel0: got %b want 1", in_ready);
        end
        sel = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_sel1: got %b want 1", in_ready);
        end
        idle_inputs();
    endtask

    task automatic test_routing();
        do_reset();
        in_valid = 1'b1; sel = 1'b0; in_dat = 32'hAAAA0001;
        tick();
        sel = 1'b1; in_dat = 32'hBBBB0002;
        tick();
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (out0 !== 32'hAAAA0001 || out0_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL routing_out0: got %h v=%b want aaaa0001 v=1", out0, out0_valid);
        end
        n_checks++;
        if (out1 !== 32'hBBBB0002 || out1_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL routing_out1: got %h v=%b want bbbb0002 v=1", out1, out1_valid);
        end
        n_checks++;
        if (cnt0 !== 4'd1 || cnt1 !== 4'd1) begin
            n_fail++;
            $display("FAIL routing_cnt: got %0d/%0d want 1/1", cnt0, cnt1);
        end
        out0_ready = 1'b1; out1_ready = 1'b1;
        tick();
        #1;
        n_checks++;
        if (out0_valid !== 1'b0 || out1_valid !== 1'b0 || out0 !== 32'h0 || out1 !== 32'h0) begin
            n_fail++;
            $display("FAIL routing_drain: got v=%b/%b d=%h/%h want 0/0 0/0", out0_valid, out1_valid, out0, out1);
        end
        idle_inputs();
    endtask

    task automatic test_full();
        do_reset();
        in_valid = 1'b1; sel = 1'b0; in_dat = 32'h1;
        tick();
        in_dat = 32'h2;
        tick();
        in_dat = 32'h3;
        #1;
        n_checks++;
        if (in_ready !== 1'b0 || cnt0 !== 4'd2) begin
            n_fail++;
            $display("FAIL full_ready: got rdy=%b cnt0=%0d want rdy=0 cnt0=2", in_ready, cnt0);
        end
        sel = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL full_other_path: got %b want 1", in_ready);
        end
        sel = 1'b0; out0_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0 || out0 !== 32'h1) begin
            n_fail++;
            $display("FAIL full_pop_cycle: got rdy=%b out0=%h want rdy=0 out0=1", in_ready, out0);
        end
        tick();
        #1;
        n_checks++;
        if (out0 !== 32'h2 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL full_second: got out0=%h rdy=%b want 2 rdy=1", out0, in_ready);
        end
        tick();
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (out0 !== 32'h3 || cnt0 !== 4'd3 || cnt1 !== 4'd0) begin
            n_fail++;
            $display("FAIL full_third: got out0=%h cnt=%0d/%0d want 3 cnt=3/0", out0, cnt0, cnt1);
        end
        tick();
        #1;
        n_checks++;
        if (out0_valid !== 1'b0 || out0 !== 32'h0) begin
            n_fail++;
            $display("FAIL full_empty: got v=%b out0=%h want v=0 out0=0", out0_valid, out0);
        end
        idle_inputs();
    endtask

    task automatic test_push_pop();
        do_reset();
        in_valid = 1'b1; sel = 1'b1; in_dat = 32'h10;
        tick();
        in_dat = 32'h20; out1_ready = 1'b1;
        #1;
        n_checks++;
        if (out1 !== 32'h10 || out1_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pushpop_before: got %h v=%b want 10 v=1", out1, out1_valid);
        end
        tick();
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (out1 !== 32'h20 || out1_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pushpop_after: got %h v=%b want 20 v=1", out1, out1_valid);
        end
        tick();
        #1;
        n_checks++;
        if (out1_valid !== 1'b0 || cnt1 !== 4'd2) begin
            n_fail++;
            $display("FAIL pushpop_occ1: got v=%b cnt1=%0d want v=0 cnt1=2", out1_valid, cnt1);
        end
        idle_inputs();
    endtask

    task automatic test_wrap();
        do_reset();
        in_valid = 1'b1; sel = 1'b0; out0_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_dat = 32'(i);
            tick();
        end
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (cnt0 !== 4'd0 || cnt1 !== 4'd0) begin
            n_fail++;
            $display("FAIL wrap_cnt: got %0d/%0d want 0/0", cnt0, cnt1);
        end
        n_checks++;
        if (out0 !== 32'd15 || out0_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_last: got %h v=%b want f v=1", out0, out0_valid);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        logic [31:0]   e0, e1;
        logic [CW-1:0] ec0, ec1;
        bit            er;
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            sel        = 1'($urandom);
            in_dat     = $urandom;
            out0_ready = ($urandom_range(0, 2) != 0);
            out1_ready = ($urandom_range(0, 2) != 0);
            #1;
            e0  = (q0.size() > 0) ? q0[0] : 32'h0;
            e1  = (q1.size() > 0) ? q1[0] : 32'h0;
            ec0 = CW'(m_cnt0 % 16);
            ec1 = CW'(m_cnt1 % 16);
            er  = (sel ? q1.size() : q0.size()) < 2;
            n_checks++;
            if (out0_valid !== (q0.size() > 0) || out0 !== e0) begin
                n_fail++;
                $display("FAIL rand_path0 cyc %0d: got v=%b %h want v=%b %h", c, out0_valid, out0, q0.size() > 0, e0);
            end
            n_checks++;
            if (out1_valid !== (q1.size() > 0) || out1 !== e1) begin
                n_fail++;
                $display("FAIL rand_path1 cyc %0d: got v=%b %h want v=%b %h", c, out1_valid, out1, q1.size() > 0, e1);
            end
            n_checks++;
            if (in_ready !== er) begin
                n_fail++;
                $display("FAIL rand_ready cyc %0d: got %b want %b", c, in_ready, er);
            end
            n_checks++;
            if (cnt0 !== ec0 || cnt1 !== ec1) begin
                n_fail++;
                $display("FAIL rand_cnt cyc %0d: got %0d/%0d want %0d/%0d", c, cnt0, cnt1, ec0, ec1);
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        test_reset();
        test_routing();
        test_full();
        test_push_pop();
        test_wrap();
        test_random();
        test_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
